// File: rtl/axis_arbiter_if.sv
// AXI-Stream bundle for axis_arbiter: NUM_SLAVES concatenated request inputs and one output.
// The master modport is the arbiter's view; slave is the surrounding sources and sink.
interface axis_arbiter_if #(
    parameter int unsigned BUS_WIDTH  = 1,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned NUM_SLAVES = 2
);
    logic [NUM_SLAVES-1:0]             s_axis_tvalid;
    logic [NUM_SLAVES-1:0]             s_axis_tready;
    logic [NUM_SLAVES-1:0]             s_axis_tlast;
    logic [NUM_SLAVES*BUS_WIDTH*8-1:0] s_axis_tdata;
    logic [NUM_SLAVES*BUS_WIDTH-1:0]   s_axis_tkeep;
    logic [NUM_SLAVES*USER_WIDTH-1:0]  s_axis_tuser;
    logic [NUM_SLAVES*DEST_WIDTH-1:0]  s_axis_tdest;

    logic                              m_axis_tvalid;
    logic                              m_axis_tready;
    logic                              m_axis_tlast;
    logic [BUS_WIDTH*8-1:0]            m_axis_tdata;
    logic [BUS_WIDTH-1:0]              m_axis_tkeep;
    logic [USER_WIDTH-1:0]             m_axis_tuser;
    logic [DEST_WIDTH-1:0]             m_axis_tdest;

    modport master (
        input  s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, s_axis_tuser,
        input  s_axis_tdest, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        output m_axis_tuser, m_axis_tdest
    );

    modport slave (
        output s_axis_tvalid, s_axis_tlast, s_axis_tdata, s_axis_tkeep, s_axis_tuser,
        output s_axis_tdest, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep,
        input  m_axis_tuser, m_axis_tdest
    );
endinterface

// File: rtl/axis_arbiter.sv
// AXI-Stream round-robin arbiter: packet-locked grant over NUM_SLAVES inputs,
// single registered output stage with full in-packet throughput.
module axis_arbiter #(
    parameter int unsigned BUS_WIDTH  = 1,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1,
    parameter int unsigned NUM_SLAVES = 2
) (
    input  logic                          aclk,
    input  logic                          arstn,
    axis_arbiter_if.master                bus,
    output logic [$clog2(NUM_SLAVES)-1:0] grant_id,
    output logic                          busy
);
    localparam int unsigned GW = $clog2(NUM_SLAVES);
    localparam int unsigned DW = BUS_WIDTH * 8;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0]            state_q, state_d;
    logic                  run_q;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic [DW-1:0]         m_data_q, m_data_d;
    logic [BUS_WIDTH-1:0]  m_keep_q, m_keep_d;
    logic [USER_WIDTH-1:0] m_user_q, m_user_d;
    logic [DEST_WIDTH-1:0] m_dest_q, m_dest_d;

    logic                  found;
    logic [GW-1:0]         pick;
    logic                  out_ready;
    logic                  accept;
    logic                  sel_last;
    logic [DW-1:0]         sel_data;
    logic [BUS_WIDTH-1:0]  sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic [DEST_WIDTH-1:0] sel_dest;

    // First valid input at or above rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_SLAVES;
            if (!found && bus.s_axis_tvalid[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        sel_last = bus.s_axis_tlast[grant_q];
        sel_data = bus.s_axis_tdata[32'(grant_q) * DW +: DW];
        sel_keep = bus.s_axis_tkeep[32'(grant_q) * BUS_WIDTH +: BUS_WIDTH];
        sel_user = bus.s_axis_tuser[32'(grant_q) * USER_WIDTH +: USER_WIDTH];
        sel_dest = bus.s_axis_tdest[32'(grant_q) * DEST_WIDTH +: DEST_WIDTH];
    end

    assign out_ready = !m_valid_q || bus.m_axis_tready;
    assign accept    = (state_q == StGrant) && bus.s_axis_tvalid[grant_q] && out_ready;

    always_comb begin
        bus.s_axis_tready = '0;
        if (state_q == StGrant) begin
            bus.s_axis_tready[grant_q] = out_ready;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = pick;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (accept && sel_last) begin
                    state_d  = StIdle;
                    rr_ptr_d = (grant_q == GW'(NUM_SLAVES - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_user_d  = m_user_q;
        m_dest_d  = m_dest_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_last_d  = sel_last;
            m_data_d  = sel_data;
            m_keep_d  = sel_keep;
            m_user_d  = sel_user;
            m_dest_d  = sel_dest;
        end else if (bus.m_axis_tready) begin
            m_valid_d = 1'b0;
        end
    end

    // run_q delays the first active edge so reset release is seen synchronously.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            run_q     <= 1'b0;
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_user_q  <= '0;
            m_dest_q  <= '0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_user_q  <= m_user_d;
            m_dest_q  <= m_dest_d;
        end
    end

    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tkeep  = m_keep_q;
    assign bus.m_axis_tuser  = m_user_q;
    assign bus.m_axis_tdest  = m_dest_q;
    assign grant_id          = grant_q;
    assign busy              = (state_q == StGrant);
endmodule

// File: tb/tb_axis_arbiter.sv
// Directed bench for axis_arbiter: a per-cycle vector table plus stream sequences for
// round-robin order, source stalls, random sink backpressure and mid-packet reset.
module tb_axis_arbiter;
    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    axis_arbiter_if #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .NUM_SLAVES(2)) bus2 ();
    axis_arbiter_if #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .NUM_SLAVES(4)) bus4 ();
    logic       g2, b2, b4;
    logic [1:0] g4;

    axis_arbiter #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .NUM_SLAVES(2)) dut2 (
        .aclk(clk), .arstn(arstn), .bus(bus2), .grant_id(g2), .busy(b2)
    );
    axis_arbiter #(.BUS_WIDTH(1), .USER_WIDTH(1), .DEST_WIDTH(1), .NUM_SLAVES(4)) dut4 (
        .aclk(clk), .arstn(arstn), .bus(bus4), .grant_id(g4), .busy(b4)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] tv;  logic [7:0] d0; logic l0; logic [7:0] d1; logic l1; logic mrdy;
        logic busy; logic gnt; logic [1:0] srdy; logic mv; logic [7:0] md; logic ml; logic src;
    } vec_t;
    vec_t tbl[17];

    // Stream entries are {last, data} for sources and {keep, user, dest, last, data} on output;
    // input 1 carries keep/user/dest = 1, input 0 carries 0.
    logic [8:0]  src_q0[$];
    logic [8:0]  src_q1[$];
    logic [11:0] exp_q[$];
    logic [11:0] out_q[$];
    int          out_cyc[$];
    int          out_gnt[$];
    int          gap_after = 0;
    int          gap_len = 0;
    bit          rand_rdy = 1'b0;

    task automatic drive_srcs(input int gap_left);
        bus2.s_axis_tvalid[0]   = (src_q0.size() > 0) && (gap_left == 0);
        bus2.s_axis_tdata[7:0]  = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
        bus2.s_axis_tlast[0]    = (src_q0.size() > 0) ? src_q0[0][8] : 1'b0;
        bus2.s_axis_tvalid[1]   = (src_q1.size() > 0);
        bus2.s_axis_tdata[15:8] = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
        bus2.s_axis_tlast[1]    = (src_q1.size() > 0) ? src_q1[0][8] : 1'b0;
        bus2.m_axis_tready      = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic stream_run(input string name, input int max_cyc);
        int   cyc, gap_left, sent0;
        logic f0, f1;
        cyc = 0; gap_left = 0; sent0 = 0;
        out_q.delete(); out_cyc.delete(); out_gnt.delete();
        drive_srcs(0);
        while (out_q.size() < exp_q.size() && cyc < max_cyc) begin
            @(negedge clk);
            if (bus2.m_axis_tvalid && bus2.m_axis_tready) begin
                out_q.push_back({bus2.m_axis_tkeep, bus2.m_axis_tuser, bus2.m_axis_tdest,
                                 bus2.m_axis_tlast, bus2.m_axis_tdata});
                out_cyc.push_back(cyc);
                out_gnt.push_back(int'(g2));
            end
            if (gap_left > 0 && b2) chk($sformatf("%s.hold_grant", name), 32'(g2), 32'd0);
            f0 = bus2.s_axis_tvalid[0] && bus2.s_axis_tready[0];
            f1 = bus2.s_axis_tvalid[1] && bus2.s_axis_tready[1];
            @(posedge clk); #1;
            if (f0) begin
                void'(src_q0.pop_front());
                sent0++;
                if (sent0 == gap_after) gap_left = gap_len;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (f1) void'(src_q1.pop_front());
            drive_srcs(gap_left);
            cyc++;
        end
        chk($sformatf("%s.count", name), 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s.beat%0d", name, i),
                (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 arstn = 1'b1;
    endtask

    int exp_gap[8] = '{1, 1, 2, 1, 1, 2, 1, 1};
    int got;

    initial begin
        tbl[0]  = '{2'b10, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 8'h00, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 8'h00, 1'b0, 8'h12, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[3]  = '{2'b10, 8'h00, 1'b0, 8'h13, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 8'h12, 1'b0, 1'b1};
        tbl[4]  = '{2'b10, 8'h00, 1'b0, 8'h14, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 8'h13, 1'b0, 1'b1};
        tbl[5]  = '{2'b00, 8'h00, 1'b0, 8'h14, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h14, 1'b1, 1'b1};
        tbl[6]  = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[8]  = '{2'b01, 8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[11] = '{2'b10, 8'h00, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{2'b10, 8'h00, 1'b0, 8'h21, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[13] = '{2'b10, 8'h00, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 8'h21, 1'b0, 1'b1};
        tbl[14] = '{2'b10, 8'h00, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 8'h21, 1'b0, 1'b1};
        tbl[15] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[16] = '{2'b00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0};

        bus4.s_axis_tvalid = '0; bus4.s_axis_tlast = '0; bus4.s_axis_tdata = '0;
        bus4.s_axis_tkeep = '0; bus4.s_axis_tuser = '0; bus4.s_axis_tdest = '0;
        bus4.m_axis_tready = 1'b1;
        bus2.s_axis_tkeep = 2'b10; bus2.s_axis_tuser = 2'b10; bus2.s_axis_tdest = 2'b10;
        bus2.s_axis_tvalid = 2'b10; bus2.s_axis_tdata = 16'h1100; bus2.s_axis_tlast = 2'b00;
        bus2.m_axis_tready = 1'b1;

        // Reset state, with in1 already requesting.
        arstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(b2), 32'd0);
        chk("rst.grant", 32'(g2), 32'd0);
        chk("rst.s_tready", 32'(bus2.s_axis_tready), 32'd0);
        chk("rst.m_tvalid", 32'(bus2.m_axis_tvalid), 32'd0);
        chk("rst.m_bus", 32'({bus2.m_axis_tkeep, bus2.m_axis_tuser, bus2.m_axis_tdest,
                              bus2.m_axis_tlast, bus2.m_axis_tdata}), 32'd0);
        chk("rst.busy4", 32'(b4), 32'd0);
        #2 arstn = 1'b1;

        for (int k = 0; k < 17; k++) begin
            @(posedge clk); #1;
            bus2.s_axis_tvalid = tbl[k].tv;
            bus2.s_axis_tdata  = {tbl[k].d1, tbl[k].d0};
            bus2.s_axis_tlast  = {tbl[k].l1, tbl[k].l0};
            bus2.m_axis_tready = tbl[k].mrdy;
            @(negedge clk);
            chk($sformatf("v%0d.busy", k), 32'(b2), 32'(tbl[k].busy));
            chk($sformatf("v%0d.grant", k), 32'(g2), 32'(tbl[k].gnt));
            chk($sformatf("v%0d.s_tready", k), 32'(bus2.s_axis_tready), 32'(tbl[k].srdy));
            chk($sformatf("v%0d.m_tvalid", k), 32'(bus2.m_axis_tvalid), 32'(tbl[k].mv));
            if (tbl[k].mv) begin
                chk($sformatf("v%0d.m_tdata", k), 32'(bus2.m_axis_tdata), 32'(tbl[k].md));
                chk($sformatf("v%0d.m_tlast", k), 32'(bus2.m_axis_tlast), 32'(tbl[k].ml));
                chk($sformatf("v%0d.m_side", k),
                    32'({bus2.m_axis_tkeep, bus2.m_axis_tuser, bus2.m_axis_tdest}),
                    32'({3{tbl[k].src}}));
            end
        end

        // Both inputs busy from reset: in0, in1, in0 with one bubble between packets.
        do_reset();
        src_q0 = '{9'h0A0, 9'h0A1, 9'h1A2, 9'h0C0, 9'h0C1, 9'h1C2};
        src_q1 = '{9'h0B0, 9'h0B1, 9'h1B2};
        exp_q  = '{12'h0A0, 12'h0A1, 12'h1A2, 12'hEB0, 12'hEB1, 12'hFB2,
                   12'h0C0, 12'h0C1, 12'h1C2};
        stream_run("rr2", 200);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("rr2.spacing%0d", i),
                (i < out_cyc.size()) ? 32'(out_cyc[i] - out_cyc[i-1]) : 32'hFFFF_FFFF,
                32'(exp_gap[i-1]));
        end
        chk("rr2.grant_a", (out_gnt.size() > 0) ? 32'(out_gnt[0]) : 32'hFFFF_FFFF, 32'd0);
        chk("rr2.grant_b", (out_gnt.size() > 3) ? 32'(out_gnt[3]) : 32'hFFFF_FFFF, 32'd1);
        chk("rr2.grant_c", (out_gnt.size() > 6) ? 32'(out_gnt[6]) : 32'hFFFF_FFFF, 32'd0);

        // rr_ptr is now 1: in1 wins, one beat sits stalled in the output, then reset hits.
        @(posedge clk); #1;
        bus2.s_axis_tvalid = 2'b11; bus2.s_axis_tdata = 16'h7060; bus2.s_axis_tlast = 2'b00;
        bus2.m_axis_tready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus2.s_axis_tdata = 16'h7160;
        @(negedge clk);
        chk("arst.pre_grant", 32'(g2), 32'd1);
        chk("arst.pre_data", 32'({bus2.m_axis_tvalid, bus2.m_axis_tdata}), 32'h170);
        @(posedge clk); #2;
        arstn = 1'b0;
        #1;
        chk("arst.m_tvalid", 32'(bus2.m_axis_tvalid), 32'd0);
        chk("arst.s_tready", 32'(bus2.s_axis_tready), 32'd0);
        chk("arst.busy", 32'(b2), 32'd0);
        chk("arst.grant", 32'(g2), 32'd0);
        chk("arst.m_tdata", 32'(bus2.m_axis_tdata), 32'd0);
        @(negedge clk);
        #2 arstn = 1'b1;
        bus2.m_axis_tready = 1'b1;
        @(negedge clk);
        chk("arst.rel_busy", 32'(b2), 32'd0);
        @(negedge clk);
        chk("arst.rel_grant", 32'({b2, g2}), 32'h2);
        @(negedge clk);
        chk("arst.first_beat", 32'({bus2.m_axis_tvalid, bus2.m_axis_tdata}), 32'h160);

        // Granted in0 drops valid for 5 cycles after its first beat; in1 must wait.
        do_reset();
        gap_after = 1; gap_len = 5;
        src_q0 = '{9'h0D0, 9'h0D1, 9'h1D2};
        src_q1 = '{9'h1E0};
        exp_q  = '{12'h0D0, 12'h0D1, 12'h1D2, 12'hFE0};
        stream_run("stall", 200);
        gap_after = 0; gap_len = 0;

        // Random sink backpressure, mixed packet lengths.
        do_reset();
        rand_rdy = 1'b1;
        src_q0 = '{9'h080, 9'h181, 9'h182};
        src_q1 = '{9'h090, 9'h091, 9'h192, 9'h193};
        exp_q  = '{12'h080, 12'h181, 12'hE90, 12'hE91, 12'hF92, 12'h182, 12'hF93};
        stream_run("rand", 400);
        rand_rdy = 1'b0;

        // Four inputs, only in1 and in3 requesting single-beat packets.
        bus4.s_axis_tvalid = 4'b1010; bus4.s_axis_tlast = 4'b1010;
        bus4.s_axis_tdata  = 32'h3300_3100;
        do_reset();
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (bus4.m_axis_tvalid) begin
                chk($sformatf("rr4.data%0d", got), 32'(bus4.m_axis_tdata),
                    (got % 2 == 1) ? 32'h33 : 32'h31);
                chk($sformatf("rr4.grant%0d", got), 32'(g4), (got % 2 == 1) ? 32'd3 : 32'd1);
                got++;
            end
        end
        chk("rr4.count", 32'(got), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
